ft_recovery_ctrl: RTL
=====================

// Module: ft_recovery_ctrl
// PURPOSE
//  Rollback controller for the DMR lockstep pair; sits after the lockstep write-back comparator.
//  Keeps a shadow (checkpoint) register file and PC, updated only by matching commits.
//  On a comparator mismatch it halts both cores and rewrites every architectural register
//  in both cores from the shadow copy, then restores the PC and resumes.
//  After MAX_RETRY consecutive recoveries with no clean commit it latches a fatal halt.
// PARAMETERS
//  ADDR_WIDTH  5             register address width; NUM_REGS = 2**ADDR_WIDTH
//  DATA_WIDTH  32            register / PC data width
//  MAX_RETRY   3             consecutive recoveries before FATAL (>=1)
//  BOOT_ADDR   32'h0000_0080 shadow PC value after reset
// PORTS
//  clk_i           in   1           clock, rising edge
//  rst_i           in   1           asynchronous reset, active-high
//  valid_instr_i   in   1           comparator inputs describe a retiring instruction this cycle
//  error_i         in   1           comparator mismatch (only meaningful with valid_instr_i)
//  we_i            in   1           agreed register-write enable of the retiring instruction
//  addr_i          in   ADDR_WIDTH  agreed destination register
//  data_i          in   DATA_WIDTH  agreed write-back data
//  pc_i            in   DATA_WIDTH  PC of the next instruction after the retiring one
//  halt_ack_i      in   1           both cores are stalled (AND of per-core acks)
//  halt_o          out  1           stall request to both cores
//  rec_we_o        out  1           recovery write strobe to both register files
//  rec_addr_o      out  ADDR_WIDTH  recovery write address
//  rec_data_o      out  DATA_WIDTH  recovery write data
//  rec_pc_valid_o  out  1           one-cycle strobe: load rec_pc_o into both PCs
//  rec_pc_o        out  DATA_WIDTH  restored PC
//  fatal_o         out  1           sticky unrecoverable-fault flag
//  err_count_o     out  8           total mismatches seen, saturates at 8'hFF
// BEHAVIOUR
//  Reset (async): state RUN; all outputs 0; shadow regs all 0; shadow PC = BOOT_ADDR; counters 0.
//  States RUN, HALT, COPY, PC_RESTORE, FATAL. All outputs registered.
//  RUN:
//   - clean commit (valid & !error): if we_i & addr_i!=0, shadow[addr_i]<=data_i;
//     shadow PC<=pc_i; retry count<=0.
//   - mismatch (valid & error): no shadow update; err_count+1 (saturating); retry count+1;
//     if the new retry count == MAX_RETRY -> FATAL, else -> HALT. halt_o=1 from next cycle.
//   - valid_instr_i=0: no action, error_i ignored.
//  HALT: halt_o=1; wait for halt_ack_i; on ack -> COPY with index=0. No timeout.
//  COPY: one register per cycle: rec_we_o=1, rec_addr_o=index, rec_data_o=shadow[index];
//   index wraps NUM_REGS-1 -> 0 and the state -> PC_RESTORE (NUM_REGS write cycles total).
//  PC_RESTORE: one cycle, rec_pc_valid_o=1, rec_pc_o=shadow PC; -> RUN; halt_o drops next cycle.
//  FATAL: halt_o=1, fatal_o=1, all rec_* 0; only reset leaves it.
//  Error latency: mismatch at edge N -> halt_o high after edge N; recovery takes
//   >= 1 + NUM_REGS + 1 cycles after halt_ack_i.
//  Shadow[0] is hardwired 0 and is written as 0 during COPY.
//  Inputs valid_instr_i/error_i/we_i are ignored outside RUN (cores are stalled).
//  halt_ack_i dropping during COPY is ignored; the sequence completes.
//  rec_data_o during COPY reflects the shadow as of entry into HALT (shadow frozen).
//  err_count_o is never cleared except by reset; the retry count is cleared only by a clean commit.
// TESTING
//  1) Reset, then 3 clean commits x1=5, x2=7, x0=9 -> shadow x1=5, x2=7, x0=0; halt_o stays 0.
//  2) After (1), mismatch; halt_ack_i after 4 cycles -> 32 rec_we_o pulses with addr 0..31,
//     data x1=5, x2=7, others 0; then rec_pc_valid_o with the last clean pc_i; halt_o falls; err_count_o=1.
//  3) Mismatch with valid_instr_i=0, and error_i=1 during COPY -> no state change, err_count_o unchanged.
//  4) 3 mismatches each followed by recovery, with no clean commit between them -> FATAL after the 3rd;
//     fatal_o=1, halt_o=1, no COPY; a clean commit between the 2nd and 3rd resets the retry count
//     so the 3rd recovers normally.
//  5) Assert rst_i mid-COPY at index 10 -> outputs 0 immediately; after release, rec_pc_o source=BOOT_ADDR.
//  6) 300 recoveries with clean commits between them -> err_count_o saturates at 255.

Source files
------------

// File: rtl/ft_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// ft_recovery_ctrl
//   Rollback controller for a dual-modular-redundant lockstep core pair. It
//   sits behind the write-back comparator and keeps a checkpoint copy of the
//   architectural register file and PC, updated only by commits on which both
//   cores agree. On a mismatch it stalls both cores, rewrites every register
//   in both cores from the checkpoint, restores the PC and resumes. After
//   MAX_RETRY consecutive recoveries without a clean commit in between it
//   latches a sticky fatal halt that only reset clears.
//
// Ports
//   clk_i, rst_i       clock (rising edge), asynchronous active-high reset
//   valid_instr_i      comparator inputs describe a retiring instruction
//   error_i            comparator mismatch, qualified by valid_instr_i
//   we_i/addr_i/data_i agreed register write-back of the retiring instruction
//   pc_i               PC of the instruction after the retiring one
//   halt_ack_i         both cores are stalled
//   halt_o             stall request to both cores
//   rec_we_o/rec_addr_o/rec_data_o  recovery register write port
//   rec_pc_valid_o     one-cycle strobe: load rec_pc_o into both PCs
//   rec_pc_o           restored PC
//   fatal_o            sticky unrecoverable-fault flag
//   err_count_o        total mismatches seen, saturating at 255
//   dbg_state          current FSM state, for observation only
//
// Handshake: halt_o is a level request; the controller waits in HALT for
// halt_ack_i to be sampled high once, after which the copy sequence runs to
// completion regardless of halt_ack_i.
// ---------------------------------------------------------------------------
module ft_recovery_ctrl #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MAX_RETRY  = 3,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = DATA_WIDTH'(32'h0000_0080)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_instr_i,
    input  logic                  error_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  halt_ack_i,
    output logic                  halt_o,
    output logic                  rec_we_o,
    output logic [ADDR_WIDTH-1:0] rec_addr_o,
    output logic [DATA_WIDTH-1:0] rec_data_o,
    output logic                  rec_pc_valid_o,
    output logic [DATA_WIDTH-1:0] rec_pc_o,
    output logic                  fatal_o,
    output logic [7:0]            err_count_o,
    output logic [2:0]            dbg_state
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int RW       = $clog2(MAX_RETRY + 1);

    localparam logic [RW-1:0]         RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = {ADDR_WIDTH{1'b1}};

    localparam logic [2:0] S_RUN        = 3'd0;
    localparam logic [2:0] S_HALT       = 3'd1;
    localparam logic [2:0] S_COPY       = 3'd2;
    localparam logic [2:0] S_PC_RESTORE = 3'd3;
    localparam logic [2:0] S_FATAL      = 3'd4;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow_pc;
    logic [RW-1:0]         retry_cnt;
    logic [RW-1:0]         retry_next;
    logic [ADDR_WIDTH-1:0] next_idx;

    assign retry_next = retry_cnt + RW'(1);
    // rec_addr_o doubles as the copy index, so the address on the port is
    // always the register whose data is presented alongside it.
    assign next_idx   = rec_addr_o + ADDR_WIDTH'(1);
    assign dbg_state  = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_RUN;
            halt_o         <= 1'b0;
            rec_we_o       <= 1'b0;
            rec_addr_o     <= '0;
            rec_data_o     <= '0;
            rec_pc_valid_o <= 1'b0;
            rec_pc_o       <= '0;
            fatal_o        <= 1'b0;
            err_count_o    <= 8'd0;
            retry_cnt      <= '0;
            shadow_pc      <= BOOT_ADDR;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (valid_instr_i) begin
                        if (!error_i) begin
                            // x0 is never written, so shadow[0] stays 0.
                            if (we_i && (addr_i != '0)) begin
                                shadow[addr_i] <= data_i;
                            end
                            shadow_pc <= pc_i;
                            retry_cnt <= '0;
                        end else begin
                            if (err_count_o != 8'hFF) begin
                                err_count_o <= err_count_o + 8'd1;
                            end
                            retry_cnt <= retry_next;
                            halt_o    <= 1'b1;
                            if (retry_next == RETRY_LIMIT) begin
                                state   <= S_FATAL;
                                fatal_o <= 1'b1;
                            end else begin
                                state <= S_HALT;
                            end
                        end
                    end
                end
                S_HALT: begin
                    if (halt_ack_i) begin
                        state      <= S_COPY;
                        rec_we_o   <= 1'b1;
                        rec_addr_o <= '0;
                        rec_data_o <= '0;
                    end
                end
                S_COPY: begin
                    if (rec_addr_o == LAST_IDX) begin
                        state          <= S_PC_RESTORE;
                        rec_we_o       <= 1'b0;
                        rec_addr_o     <= '0;
                        rec_data_o     <= '0;
                        rec_pc_valid_o <= 1'b1;
                        rec_pc_o       <= shadow_pc;
                    end else begin
                        rec_addr_o <= next_idx;
                        rec_data_o <= shadow[next_idx];
                    end
                end
                S_PC_RESTORE: begin
                    state          <= S_RUN;
                    rec_pc_valid_o <= 1'b0;
                    rec_pc_o       <= '0;
                    halt_o         <= 1'b0;
                end
                S_FATAL: begin
                    halt_o  <= 1'b1;
                    fatal_o <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park safely in the fatal halt.
                    state   <= S_FATAL;
                    halt_o  <= 1'b1;
                    fatal_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
